// File: rtl/sprite_motion_ctrl.sv
// sprite_motion_ctrl: per-frame sprite mover with key decode, speed ramp and edge policy.
// Optional feature macro: SPRITE_ACCEL_EN (acceleration/coasting; default build jumps to MAX_SPEED).
module sprite_motion_ctrl #(
  parameter int W         = 10,
  parameter int X_MIN     = 0,
  parameter int X_MAX     = 639,
  parameter int Y_MIN     = 0,
  parameter int Y_MAX     = 479,
  parameter int X_CENTER  = 320,
  parameter int Y_CENTER  = 240,
  parameter int SIZE      = 4,
  parameter int MAX_SPEED = 4,
  parameter int ACCEL_DIV = 4,
  parameter int EDGE_MODE = 0,
  parameter logic [7:0] KEY_UP    = 8'h1A,
  parameter logic [7:0] KEY_DOWN  = 8'h16,
  parameter logic [7:0] KEY_LEFT  = 8'h04,
  parameter logic [7:0] KEY_RIGHT = 8'h07
) (
  input  logic         frame_clk,
  input  logic         Reset_n,
  input  logic         Pause,
  input  logic [15:0]  key,
  output logic [W-1:0] PosX,
  output logic [W-1:0] PosY,
  output logic [W-1:0] Size,
  output logic [2:0]   Dir,
  output logic [W-1:0] Speed,
  output logic         Moving,
  output logic         Hit_edge
);

  localparam int SW = W + 2;

  localparam logic [2:0] D_IDLE  = 3'd0;
  localparam logic [2:0] D_UP    = 3'd1;
  localparam logic [2:0] D_DOWN  = 3'd2;
  localparam logic [2:0] D_LEFT  = 3'd3;
  localparam logic [2:0] D_RIGHT = 3'd4;

  localparam logic signed [SW-1:0] X_LO = SW'(X_MIN + SIZE);
  localparam logic signed [SW-1:0] X_HI = SW'(X_MAX - SIZE);
  localparam logic signed [SW-1:0] Y_LO = SW'(Y_MIN + SIZE);
  localparam logic signed [SW-1:0] Y_HI = SW'(Y_MAX - SIZE);

  localparam logic [W-1:0] X_RST   = W'(X_CENTER);
  localparam logic [W-1:0] Y_RST   = W'(Y_CENTER);
  localparam logic [W-1:0] SPD_MAX = W'(MAX_SPEED);
  localparam logic [W-1:0] SPD_ONE = W'(1);

  localparam bit MODE_CLAMP  = (EDGE_MODE == 0);
  localparam bit MODE_BOUNCE = (EDGE_MODE == 1);

  logic [W-1:0] pos_x;
  logic [W-1:0] pos_y;
  logic [2:0]   dir;
  logic [W-1:0] speed;
  logic         moving;
  logic         hit;

  logic [2:0]   dec_lo;
  logic [2:0]   dec_hi;
  logic [2:0]   key_dir;

  logic [2:0]   kd_dir;
  logic [W-1:0] kd_spd;

  logic signed [SW-1:0] stp;
  logic signed [SW-1:0] cand_x;
  logic signed [SW-1:0] cand_y;
  logic signed [SW-1:0] ax_cand;
  logic signed [SW-1:0] ax_lo;
  logic signed [SW-1:0] ax_hi;
  logic                 on_x;
  logic                 on_y;
  logic                 hit_lo;
  logic                 hit_hi;
  logic                 edge_hit;
  logic [W-1:0]         edge_pos;

  logic [W-1:0] nx_x;
  logic [W-1:0] nx_y;
  logic [2:0]   nx_dir;
  logic [W-1:0] nx_spd;

`ifdef SPRITE_ACCEL_EN
  localparam int CW = (ACCEL_DIV > 1) ? $clog2(ACCEL_DIV) : 1;
  localparam logic [CW-1:0] CNT_TOP = CW'(ACCEL_DIV - 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] kd_cnt;
  logic [CW-1:0] nx_cnt;
`endif

  function automatic logic [2:0] decode(
    input logic [7:0] code
  );
    logic [2:0] d;
    d = D_IDLE;
    unique case (1'b1)
      (code == KEY_UP):    d = D_UP;
      (code == KEY_DOWN):  d = D_DOWN;
      (code == KEY_LEFT):  d = D_LEFT;
      (code == KEY_RIGHT): d = D_RIGHT;
      default:             d = D_IDLE;
    endcase
    return d;
  endfunction

  function automatic logic [2:0] opposite(
    input logic [2:0] d
  );
    logic [2:0] o;
    o = D_IDLE;
    unique case (d)
      D_UP:    o = D_DOWN;
      D_DOWN:  o = D_UP;
      D_LEFT:  o = D_RIGHT;
      D_RIGHT: o = D_LEFT;
      default: o = D_IDLE;
    endcase
    return o;
  endfunction

  // Key decode: low byte has priority, unknown codes read as no key.
  always_comb begin
    dec_lo  = decode(key[7:0]);
    dec_hi  = decode(key[15:8]);
    key_dir = (dec_lo != D_IDLE) ? dec_lo : dec_hi;
  end

`ifdef SPRITE_ACCEL_EN
  // Key-driven Dir/Speed: ramp up while held, coast down on release.
  always_comb begin
    kd_dir = dir;
    kd_spd = speed;
    kd_cnt = cnt;
    if (key_dir != D_IDLE) begin
      if (key_dir != dir) begin
        kd_dir = key_dir;
        kd_spd = SPD_ONE;
        kd_cnt = '0;
      end else if (cnt == CNT_TOP) begin
        kd_cnt = '0;
        if (speed < SPD_MAX) begin
          kd_spd = speed + SPD_ONE;
        end
      end else begin
        kd_cnt = cnt + CW'(1);
      end
    end else if (dir != D_IDLE) begin
      if (speed == '0) begin
        kd_dir = D_IDLE;
        kd_cnt = '0;
      end else if (cnt == CNT_TOP) begin
        kd_cnt = '0;
        kd_spd = speed - SPD_ONE;
        if (speed == SPD_ONE) begin
          kd_dir = D_IDLE;
        end
      end else begin
        kd_cnt = cnt + CW'(1);
      end
    end
  end
`else
  // Key-driven Dir/Speed: full speed while held, stop on release.
  always_comb begin
    kd_dir = D_IDLE;
    kd_spd = '0;
    if (key_dir != D_IDLE) begin
      kd_dir = key_dir;
      kd_spd = SPD_MAX;
    end
  end
`endif

  // Candidate position from the current registered Dir/Speed, widened and signed.
  always_comb begin
    stp    = $signed({2'b00, speed});
    cand_x = $signed({2'b00, pos_x});
    cand_y = $signed({2'b00, pos_y});
    unique case (dir)
      D_UP:    cand_y = cand_y - stp;
      D_DOWN:  cand_y = cand_y + stp;
      D_LEFT:  cand_x = cand_x - stp;
      D_RIGHT: cand_x = cand_x + stp;
      default: ;
    endcase
  end

  // Bound check on the moving axis and the position the edge policy lands on.
  always_comb begin
    on_x     = (dir == D_LEFT) || (dir == D_RIGHT);
    on_y     = (dir == D_UP) || (dir == D_DOWN);
    ax_cand  = on_x ? cand_x : cand_y;
    ax_lo    = on_x ? X_LO : Y_LO;
    ax_hi    = on_x ? X_HI : Y_HI;
    hit_lo   = (on_x || on_y) && (ax_cand < ax_lo);
    hit_hi   = (on_x || on_y) && (ax_cand > ax_hi);
    edge_hit = hit_lo || hit_hi;
    edge_pos = ax_cand[W-1:0];
    if (hit_lo) begin
      edge_pos = (MODE_CLAMP || MODE_BOUNCE) ?
                 ax_lo[W-1:0] : ax_hi[W-1:0];
    end else if (hit_hi) begin
      edge_pos = (MODE_CLAMP || MODE_BOUNCE) ?
                 ax_hi[W-1:0] : ax_lo[W-1:0];
    end
  end

  // Next state: edge action overrides the key-driven update.
  always_comb begin
    nx_x   = pos_x;
    nx_y   = pos_y;
    nx_dir = kd_dir;
    nx_spd = kd_spd;
`ifdef SPRITE_ACCEL_EN
    nx_cnt = kd_cnt;
`endif
    if (on_x) begin
      nx_x = edge_pos;
    end
    if (on_y) begin
      nx_y = edge_pos;
    end
    if (edge_hit) begin
      if (MODE_CLAMP) begin
        nx_dir = D_IDLE;
        nx_spd = '0;
`ifdef SPRITE_ACCEL_EN
        nx_cnt = '0;
`endif
      end else if (MODE_BOUNCE) begin
        nx_dir = opposite(dir);
        nx_spd = speed;
`ifdef SPRITE_ACCEL_EN
        nx_cnt = '0;
`endif
      end
    end
  end

  // State registers: reset, then pause hold, then frame update.
  always_ff @(posedge frame_clk) begin
    if (!Reset_n) begin
      pos_x  <= X_RST;
      pos_y  <= Y_RST;
      dir    <= D_IDLE;
      speed  <= '0;
      moving <= 1'b0;
      hit    <= 1'b0;
`ifdef SPRITE_ACCEL_EN
      cnt    <= '0;
`endif
    end else if (Pause) begin
      hit    <= 1'b0;
    end else begin
      pos_x  <= nx_x;
      pos_y  <= nx_y;
      dir    <= nx_dir;
      speed  <= nx_spd;
      moving <= (nx_dir != D_IDLE);
      hit    <= edge_hit;
`ifdef SPRITE_ACCEL_EN
      cnt    <= nx_cnt;
`endif
    end
  end

  assign PosX     = pos_x;
  assign PosY     = pos_y;
  assign Size     = W'(SIZE);
  assign Dir      = dir;
  assign Speed    = speed;
  assign Moving   = moving;
  assign Hit_edge = hit;

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// tb_sprite_motion_ctrl: scoreboard bench over four edge-policy variants.
// Expectations follow SPRITE_ACCEL_EN when it is defined.
module tb_sprite_motion_ctrl;

  logic        frame_clk;
  logic        Reset_n;
  logic        Pause;
  logic [15:0] key;

  logic [9:0] px  [4];
  logic [9:0] py  [4];
  logic [9:0] psz [4];
  logic [2:0] pd  [4];
  logic [9:0] ps  [4];
  logic       pm  [4];
  logic       ph  [4];

  // inst 0: defaults; 1: clamp, 2: bounce, 3: wrap (all X_CENTER=634)
  for (genvar g = 0; g < 4; g++) begin : g_dut
    sprite_motion_ctrl #(
      .X_CENTER  ((g == 0) ? 320 : 634),
      .EDGE_MODE ((g == 0) ? 0 : g - 1)
    ) u_dut (
      .frame_clk (frame_clk),
      .Reset_n   (Reset_n),
      .Pause     (Pause),
      .key       (key),
      .PosX      (px[g]),
      .PosY      (py[g]),
      .Size      (psz[g]),
      .Dir       (pd[g]),
      .Speed     (ps[g]),
      .Moving    (pm[g]),
      .Hit_edge  (ph[g])
    );
  end

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  typedef struct {
    int    edge_no;
    int    inst;
    string name;
    int    x;
    int    y;
    int    d;
    int    s;
    int    h;
  } exp_t;

  exp_t q[$];
  int   edge_no = 0;
  int   checks  = 0;
  int   errors  = 0;

`ifdef SPRITE_ACCEL_EN
  localparam int S1 = 1;
  int ramp_x [6]  = '{320, 321, 322, 323, 324, 326};
  int ramp_s [6]  = '{1, 1, 1, 1, 2, 2};
  int coast_y [15] = '{240, 239, 238, 237, 236, 234, 232, 230,
                       228, 227, 226, 225, 224, 224, 224};
  int coast_d [15] = '{1, 1, 1, 1, 1, 1, 1, 1,
                       1, 1, 1, 1, 0, 0, 0};
  int coast_s [15] = '{1, 1, 1, 1, 2, 2, 2, 2,
                       1, 1, 1, 1, 0, 0, 0};
  int ed_x [3][4] = '{'{634, 635, 635, 635},
                      '{634, 635, 635, 634},
                      '{634, 635, 4, 5}};
  int ed_d [3][4] = '{'{4, 4, 0, 4},
                      '{4, 4, 3, 4},
                      '{4, 4, 4, 4}};
  int ed_s [3][4] = '{'{1, 1, 0, 1},
                      '{1, 1, 1, 1},
                      '{1, 1, 1, 1}};
  int ed_h [3][4] = '{'{0, 0, 1, 0},
                      '{0, 0, 1, 0},
                      '{0, 0, 1, 0}};
`else
  localparam int S1 = 4;
  int ramp_x [6]  = '{320, 324, 328, 332, 336, 340};
  int ramp_s [6]  = '{4, 4, 4, 4, 4, 4};
  int coast_y [15] = '{240, 236, 232, 228, 224, 220, 220, 220,
                       220, 220, 220, 220, 220, 220, 220};
  int coast_d [15] = '{1, 1, 1, 1, 1, 0, 0, 0,
                       0, 0, 0, 0, 0, 0, 0};
  int coast_s [15] = '{4, 4, 4, 4, 4, 0, 0, 0,
                       0, 0, 0, 0, 0, 0, 0};
  int ed_x [3][4] = '{'{634, 635, 635, 635},
                      '{634, 635, 631, 635},
                      '{634, 4, 8, 12}};
  int ed_d [3][4] = '{'{4, 0, 4, 0},
                      '{4, 3, 4, 4},
                      '{4, 4, 4, 4}};
  int ed_s [3][4] = '{'{4, 0, 4, 0},
                      '{4, 4, 4, 4},
                      '{4, 4, 4, 4}};
  int ed_h [3][4] = '{'{0, 1, 0, 1},
                      '{0, 1, 0, 0},
                      '{0, 1, 0, 0}};
`endif

  exp_t e;
  int   ax, ay, ad, as, am, ah, asz;

  // Monitor: after each frame edge, pop and compare every expectation due.
  always @(posedge frame_clk) begin
    #1;
    edge_no++;
    while (q.size() > 0 && q[0].edge_no <= edge_no) begin
      e   = q.pop_front();
      ax  = int'(px[e.inst]);
      ay  = int'(py[e.inst]);
      ad  = int'(pd[e.inst]);
      as  = int'(ps[e.inst]);
      am  = int'(pm[e.inst]);
      ah  = int'(ph[e.inst]);
      asz = int'(psz[e.inst]);
      checks++;
      if (ax != e.x || ay != e.y || ad != e.d || as != e.s ||
          ah != e.h || am != int'(e.d != 0) || asz != 4) begin
        errors++;
        $display({"FAIL %s inst%0d edge%0d: got x=%0d y=%0d dir=%0d",
                  " spd=%0d mov=%0d hit=%0d size=%0d; want x=%0d",
                  " y=%0d dir=%0d spd=%0d mov=%0d hit=%0d size=4"},
                 e.name, e.inst, e.edge_no, ax, ay, ad, as, am, ah,
                 asz, e.x, e.y, e.d, e.s, int'(e.d != 0), e.h);
      end
    end
  end

  task automatic drive(
    input logic        rn,
    input logic        p,
    input logic [15:0] k
  );
    Reset_n = rn;
    Pause   = p;
    key     = k;
  endtask

  task automatic push(
    input int    inst,
    input string nm,
    input int    x,
    input int    y,
    input int    d,
    input int    s,
    input int    h
  );
    exp_t t;
    t.edge_no = edge_no + 1;
    t.inst    = inst;
    t.name    = nm;
    t.x       = x;
    t.y       = y;
    t.d       = d;
    t.s       = s;
    t.h       = h;
    q.push_back(t);
  endtask

  task automatic tick();
    @(negedge frame_clk);
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 16'h0000);
    push(0, "reset", 320, 240, 0, 0, 0);
    for (int g = 1; g < 4; g++) begin
      push(g, "reset", 634, 240, 0, 0, 0);
    end
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: run did not reach its end");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(1'b0, 1'b0, 16'h0000);

    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b0, 16'h0007);
      push(0, "ramp", ramp_x[i], 240, 4, ramp_s[i], 0);
      tick();
    end

    do_reset();
    for (int i = 0; i < 15; i++) begin
      drive(1'b1, 1'b0, (i < 5) ? 16'h001A : 16'h0000);
      push(0, "coast", 320, coast_y[i], coast_d[i], coast_s[i], 0);
      tick();
    end

    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 16'h0007);
      for (int g = 1; g < 4; g++) begin
        push(g, "edge", ed_x[g-1][i], 240, ed_d[g-1][i],
             ed_s[g-1][i], ed_h[g-1][i]);
      end
      tick();
    end

    do_reset();
    drive(1'b1, 1'b0, 16'h0704);
    push(0, "decode_lo", 320, 240, 3, S1, 0);
    tick();
    drive(1'b1, 1'b0, 16'h0704);
    push(0, "decode_lo", 320 - S1, 240, 3, S1, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 16'h0016);
      push(0, "pause", 320 - S1, 240, 3, S1, 0);
      tick();
    end
    drive(1'b1, 1'b0, 16'h0704);
    push(0, "resume", 320 - 2 * S1, 240, 3, S1, 0);
    tick();
    drive(1'b1, 1'b0, 16'h1AFF);
    push(0, "decode_hi", 320 - 3 * S1, 240, 1, S1, 0);
    tick();
    drive(1'b1, 1'b0, 16'h1AFF);
    push(0, "decode_hi", 320 - 3 * S1, 240 - S1, 1, S1, 0);
    tick();

    do_reset();
`ifdef SPRITE_ACCEL_EN
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 1'b0, 16'h001A);
      if (i == 8) begin
        push(0, "mid_motion", 320, 228, 1, 3, 0);
      end
      tick();
    end
`else
    drive(1'b1, 1'b0, 16'h0016);
    push(0, "mid_motion", 320, 240, 2, 4, 0);
    tick();
    drive(1'b1, 1'b0, 16'h0016);
    push(0, "mid_motion", 320, 244, 2, 4, 0);
    tick();
`endif
    do_reset();
    drive(1'b1, 1'b0, 16'h0000);
    push(0, "idle_after_reset", 320, 240, 0, 0, 0);
    tick();

    tick();
    tick();
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, want 0",
               q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
